// File: rtl/result_uart_reporter.sv
// ============================================================================
// result_uart_reporter : turns each new pass/fail verdict into a 9-byte ASCII
// UART 8N1 report ("G<d>:PASS\r\n" etc.), drives verdict LEDs, counts reports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_uart_reporter #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pass_i,
  input  logic       fail_i,
  input  logic [2:0] gate_id_i,
  input  logic       report_en_i,
  output logic       uart_tx_o,
  output logic       busy_o,
  output logic       led_pass_o,
  output logic       led_fail_o,
  output logic [7:0] sent_count_o
);

  localparam int            DIV  = CLK_HZ / BAUD;
  localparam int            TW   = $clog2(DIV);
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    verdict_q;
  logic          pend_q, pend_d;
  logic [1:0]    pend_kind_q, pend_kind_d;
  logic [2:0]    pend_gate_q, pend_gate_d;
  logic [1:0]    msg_kind_q, msg_kind_d;
  logic [2:0]    msg_gate_q, msg_gate_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          led_pass_q, led_pass_d;
  logic          led_fail_q, led_fail_d;
  logic [7:0]    sent_q, sent_d;
  logic [1:0]    cur_w;
  logic          event_w;

  function automatic logic [7:0] byte_of(input logic [3:0] idx, input logic [1:0] kind,
                                          input logic [2:0] gate);
    logic [31:0] word;
    logic [7:0]  b;
    case (kind)
      2'b10:   word = 32'h5041_5353;
      2'b01:   word = 32'h4641_494C;
      default: word = 32'h4552_5220;
    endcase
    case (idx)
      4'd0:    b = 8'h47;
      4'd1:    b = 8'h30 + {5'b0, gate};
      4'd2:    b = 8'h3A;
      4'd3:    b = word[31:24];
      4'd4:    b = word[23:16];
      4'd5:    b = word[15:8];
      4'd6:    b = word[7:0];
      4'd7:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  assign cur_w   = {pass_i, fail_i};
  assign event_w = (cur_w != verdict_q) && (cur_w != 2'b00);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_kind_d = pend_kind_q;
    pend_gate_d = pend_gate_q;
    msg_kind_d  = msg_kind_q;
    msg_gate_d  = msg_gate_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    timer_d     = timer_q;
    shreg_d     = shreg_q;
    led_pass_d  = led_pass_q;
    led_fail_d  = led_fail_q;
    sent_d      = sent_q;
    tx_d        = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          msg_kind_d = pend_kind_q;
          msg_gate_d = pend_gate_q;
          led_pass_d = pend_kind_q[1];
          led_fail_d = pend_kind_q[0];
          pend_d     = 1'b0;
          byte_idx_d = 4'd0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d   = byte_of(byte_idx_q, msg_kind_q, msg_gate_q);
        timer_d   = '0;
        bit_idx_d = 3'd0;
        state_d   = S_START;
      end
      S_START: begin
        tx_d = 1'b0;
        if (timer_q == TMAX) begin
          timer_d = '0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        tx_d = shreg_q[0];
        if (timer_q == TMAX) begin
          timer_d   = '0;
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (timer_q == TMAX) begin
          timer_d    = '0;
          byte_idx_d = byte_idx_q + 4'd1;
          state_d    = (byte_idx_q == 4'd8) ? S_DONE : S_LOAD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        sent_d  = sent_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Capture after the IDLE hand-off so a same-cycle event refills the slot.
    if (event_w && report_en_i) begin
      pend_d      = 1'b1;
      pend_kind_d = cur_w;
      pend_gate_d = gate_id_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      verdict_q   <= 2'b00;
      pend_q      <= 1'b0;
      pend_kind_q <= 2'b00;
      pend_gate_q <= 3'd0;
      msg_kind_q  <= 2'b00;
      msg_gate_q  <= 3'd0;
      byte_idx_q  <= 4'd0;
      bit_idx_q   <= 3'd0;
      timer_q     <= '0;
      shreg_q     <= 8'h00;
      tx_q        <= 1'b1;
      led_pass_q  <= 1'b0;
      led_fail_q  <= 1'b0;
      sent_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      verdict_q   <= cur_w;
      pend_q      <= pend_d;
      pend_kind_q <= pend_kind_d;
      pend_gate_q <= pend_gate_d;
      msg_kind_q  <= msg_kind_d;
      msg_gate_q  <= msg_gate_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
      timer_q     <= timer_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      led_pass_q  <= led_pass_d;
      led_fail_q  <= led_fail_d;
      sent_q      <= sent_d;
    end
  end

  assign uart_tx_o    = tx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign led_pass_o   = led_pass_q;
  assign led_fail_o   = led_fail_q;
  assign sent_count_o = sent_q;

endmodule

`default_nettype wire

// File: tb/tb_result_uart_reporter.sv
// ============================================================================
// tb_result_uart_reporter : scoreboard bench; a UART receiver pops expected
// report bytes as frames arrive on the serial line.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_uart_reporter;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pass_i = 1'b0;
  logic       fail_i = 1'b0;
  logic [2:0] gate_id_i = 3'd0;
  logic       report_en_i = 1'b0;
  logic       uart_tx_o;
  logic       busy_o;
  logic       led_pass_o;
  logic       led_fail_o;
  logic [7:0] sent_count_o;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         rx_bytes = 0;
  int         rx_starts = 0;
  logic       rst_seen = 1'b1;
  logic [7:0] exp_q[$];

  result_uart_reporter #(.CLK_HZ(1000), .BAUD(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pass_i      (pass_i),
    .fail_i      (fail_i),
    .gate_id_i   (gate_id_i),
    .report_en_i (report_en_i),
    .uart_tx_o   (uart_tx_o),
    .busy_o      (busy_o),
    .led_pass_o  (led_pass_o),
    .led_fail_o  (led_fail_o),
    .sent_count_o(sent_count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_seen = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_msg(input logic [2:0] g, input logic [1:0] k);
    logic [31:0] w;
    case (k)
      2'b10:   w = 32'h5041_5353;
      2'b01:   w = 32'h4641_494C;
      default: w = 32'h4552_5220;
    endcase
    exp_q.push_back(8'h47);
    exp_q.push_back(8'h30 + {5'b0, g});
    exp_q.push_back(8'h3A);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      failures++;
      $display("FAIL %s: timeout, queue=%0d busy=%0b expected empty/idle", name, exp_q.size(), busy_o);
    end
    repeat (5) @(negedge clk);
  endtask

  // UART receiver / scoreboard checker
  initial begin : monitor
    logic [7:0] data;
    logic       start_ok;
    logic       stop_ok;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx_o == 1'b0) begin
        rst_seen = 1'b0;
        rx_starts++;
        repeat (DIV / 2) @(negedge clk);
        start_ok = (uart_tx_o == 1'b0);
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          data[b] = uart_tx_o;
        end
        repeat (DIV) @(negedge clk);
        stop_ok = uart_tx_o;
        if (!rst_seen) begin
          rx_bytes++;
          checks++;
          if (!start_ok || !stop_ok) begin
            failures++;
            $display("FAIL rx_frame: start=%0b stop=%0b expected start=0 stop=1", start_ok, stop_ok);
          end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rx_unexpected: got byte 0x%02h expected none", data);
          end else begin
            e = exp_q.pop_front();
            if (data !== e) begin
              failures++;
              $display("FAIL rx_byte: got 0x%02h expected 0x%02h", data, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int n;
    int k;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("reset_tx", uart_tx_o, 1);
    chk("reset_busy", busy_o, 0);
    chk("reset_sent", sent_count_o, 0);
    chk("reset_leds", {led_pass_o, led_fail_o}, 2'b00);
    chk("idle_no_start", rx_starts, 0);

    // PASS on gate 3, then FAIL and ERR on gate 5 while busy
    gate_id_i = 3'd3; report_en_i = 1'b1; pass_i = 1'b1;
    push_msg(3'd3, 2'b10);
    repeat (20) @(negedge clk);
    chk("busy_in_frame", busy_o, 1);
    chk("led_at_start", {led_pass_o, led_fail_o}, 2'b10);
    repeat (30) @(negedge clk);
    gate_id_i = 3'd5; pass_i = 1'b0; fail_i = 1'b1;
    repeat (10) @(negedge clk);
    pass_i = 1'b1;
    push_msg(3'd5, 2'b11);
    n = 0;
    while (sent_count_o != 8'd1 && n < 1500) begin @(negedge clk); n++; end
    chk("first_report_count", sent_count_o, 1);
    wait_idle("err_report", 2500);
    chk("sent_after_two", sent_count_o, 2);
    chk("led_err", {led_pass_o, led_fail_o}, 2'b11);
    chk("busy_after_two", busy_o, 0);

    // Disabled reports are dropped; holding a verdict is not an event
    report_en_i = 1'b0; pass_i = 1'b0; fail_i = 1'b0;
    repeat (3) @(negedge clk);
    base = rx_starts;
    pass_i = 1'b1;
    repeat (2000) @(negedge clk);
    chk("disabled_no_tx", rx_starts, base);
    report_en_i = 1'b1;
    repeat (200) @(negedge clk);
    chk("held_no_tx", rx_starts, base);
    chk("held_sent", sent_count_o, 2);
    chk("held_busy", busy_o, 0);

    // FAIL on gate 0 with latency measurement
    gate_id_i = 3'd0; pass_i = 1'b0; fail_i = 1'b1;
    k = cyc + 1;
    push_msg(3'd0, 2'b01);
    n = 0;
    while (uart_tx_o != 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("tx_latency", cyc, k + 3);
    wait_idle("fail_report", 1500);
    chk("sent_after_fail", sent_count_o, 3);
    chk("led_fail", {led_pass_o, led_fail_o}, 2'b01);

    // Asynchronous reset in the middle of byte 4
    gate_id_i = 3'd2; pass_i = 1'b1; fail_i = 1'b0;
    push_msg(3'd2, 2'b10);
    base = rx_bytes;
    n = 0;
    while (rx_bytes < base + 4 && n < 1000) begin @(negedge clk); n++; end
    chk("bytes_before_reset", rx_bytes, base + 4);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_tx", uart_tx_o, 1);
    chk("async_busy", busy_o, 0);
    chk("async_sent", sent_count_o, 0);
    chk("async_leds", {led_pass_o, led_fail_o}, 2'b00);
    repeat (120) @(negedge clk);
    exp_q.delete();
    push_msg(3'd2, 2'b10);
    rst_n = 1'b1;
    wait_idle("post_reset_report", 1500);
    chk("post_reset_sent", sent_count_o, 1);
    chk("post_reset_led", {led_pass_o, led_fail_o}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
